// File: rtl/spi_regif_pkg.sv
// Shared types and constants for the SPI register-interface slave.
package spi_regif_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   // Flops in each pin synchroniser chain.
   localparam int unsigned SYNC_STAGES = 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_regif_sync.sv
// Pin synchroniser for the SPI slave: sclk/ss/mosi enter the clk domain
// through SYNC_STAGES flops; edges are detected and registered, so every
// event and level leaves this block 3 clk after the pin transition.
module spi_regif_sync
   import spi_regif_pkg::*;
#(
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic ss,
   input  logic mosi,
   output logic smp,
   output logic shf,
   output logic ss_fall,
   output logic ss_rise,
   output logic ss_lvl,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] ss_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_prev;
   logic                   ss_prev;
   logic                   sclk_c;
   logic                   ss_c;
   logic                   lead_c;
   logic                   trail_c;

   assign sclk_c  = sclk_sr[SYNC_STAGES-1];
   assign ss_c    = ss_sr[SYNC_STAGES-1];
   // Leading edge leaves the CPOL idle level, trailing edge returns to it.
   assign lead_c  = CPOL ? (sclk_prev & ~sclk_c) : (~sclk_prev & sclk_c);
   assign trail_c = CPOL ? (~sclk_prev & sclk_c) : (sclk_prev & ~sclk_c);

   // Synchronise pins and register mode-selected edge events.
   // ss resets low so a select already active at reset release is not seen
   // as a fresh falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sr   <= {SYNC_STAGES{CPOL}};
         ss_sr     <= '0;
         mosi_sr   <= '0;
         sclk_prev <= CPOL;
         ss_prev   <= 1'b0;
         smp       <= 1'b0;
         shf       <= 1'b0;
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
         ss_lvl    <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         ss_sr     <= {ss_sr[SYNC_STAGES-2:0], ss};
         mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_c;
         ss_prev   <= ss_c;
         smp       <= CPHA ? trail_c : lead_c;
         shf       <= CPHA ? lead_c : trail_c;
         ss_fall   <= ss_prev & ~ss_c;
         ss_rise   <= ~ss_prev & ss_c;
         ss_lvl    <= ss_c;
         mosi_s    <= mosi_sr[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/spi_regif_slave.sv
// SPI slave bridging an external master to the register bank.
// Frame: cmd bit, ADDR_W address bits, DATA_W data bits, MSB first.
// Optional macro SPI_REGIF_BURST_EN: auto-increment burst instead of HOLD.
module spi_regif_slave
   import spi_regif_pkg::*;
#(
   parameter bit          CPOL   = 1'b0,
   parameter bit          CPHA   = 1'b0,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_out,
   output logic              we,
   output logic              re,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              frame_err
);

   localparam int unsigned SH_W  = max_u(ADDR_W, DATA_W);
   localparam int unsigned CNT_W = $clog2(SH_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic smp, shf, ss_fall, ss_rise, ss_lvl, mosi_s;

   state_t            state, state_d, st_c;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              cmd_wr, cmd_wr_d;
   logic [SH_W-2:0]   sh, sh_d;
   logic [SH_W-1:0]   sh_n_c;
   logic [ADDR_W-1:0] addr_q, addr_q_d;
   logic [DATA_W-1:0] tx, tx_d;
   logic              rd_pend, rd_pend_d;
   logic              wd, wd_d;
   logic              armed, armed_d;
   logic              fin_c;
   logic              miso_d, oe_d, we_d, re_d, busy_d, err_d;
   logic [ADDR_W-1:0] address_d;
   logic [DATA_W-1:0] data_out_d;

   spi_regif_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk),
      .ss      (ss),
      .mosi    (mosi),
      .smp     (smp),
      .shf     (shf),
      .ss_fall (ss_fall),
      .ss_rise (ss_rise),
      .ss_lvl  (ss_lvl),
      .mosi_s  (mosi_s)
   );

   assign sh_n_c = {sh, mosi_s};

   // State register and all registered datapath/outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cmd_wr    <= CMD_READ;
         sh        <= '0;
         addr_q    <= '0;
         tx        <= '0;
         rd_pend   <= 1'b0;
         wd        <= 1'b0;
         armed     <= 1'b0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         address   <= '0;
         data_out  <= '0;
         we        <= 1'b0;
         re        <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         cmd_wr    <= cmd_wr_d;
         sh        <= sh_d;
         addr_q    <= addr_q_d;
         tx        <= tx_d;
         rd_pend   <= rd_pend_d;
         wd        <= wd_d;
         armed     <= armed_d;
         miso      <= miso_d;
         miso_oe   <= oe_d;
         address   <= address_d;
         data_out  <= data_out_d;
         we        <= we_d;
         re        <= re_d;
         busy      <= busy_d;
         frame_err <= err_d;
      end
   end

   // Next-state, bit counting, shifting and strobe generation.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      cmd_wr_d   = cmd_wr;
      sh_d       = sh;
      addr_q_d   = addr_q;
      tx_d       = tx;
      rd_pend_d  = re;
      wd_d       = wd;
      armed_d    = armed | ss_lvl;
      fin_c      = 1'b0;
      miso_d     = miso;
      address_d  = address;
      data_out_d = data_out;
      we_d       = 1'b0;
      re_d       = 1'b0;
      err_d      = 1'b0;

      // Read data arrives one clk after the re strobe.
      if (rd_pend) tx_d = data_in;

      case (state)
         ST_IDLE: begin
            if (ss_fall && armed) begin
               state_d = ST_CMD;
               cnt_d   = '0;
               wd_d    = 1'b0;
            end
         end
         ST_CMD: begin
            if (smp) begin
               cmd_wr_d = mosi_s;
               state_d  = ST_ADDR;
               cnt_d    = '0;
            end
         end
         ST_ADDR: begin
            if (smp) begin
               sh_d = sh_n_c[SH_W-2:0];
               if (cnt == ADDR_LAST) begin
                  addr_q_d = sh_n_c[ADDR_W-1:0];
                  state_d  = ST_DATA;
                  cnt_d    = '0;
                  fin_c    = 1'b1;
                  if (cmd_wr == CMD_READ) begin
                     address_d = sh_n_c[ADDR_W-1:0];
                     re_d      = 1'b1;
                  end
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
         end
         ST_DATA: begin
            if (shf && (cmd_wr == CMD_READ)) begin
               miso_d = tx[DATA_W-1];
               tx_d   = {tx[DATA_W-2:0], 1'b0};
            end
            if (smp) begin
               sh_d = sh_n_c[SH_W-2:0];
               if (cnt == DATA_LAST) begin
                  cnt_d = '0;
                  fin_c = 1'b1;
                  wd_d  = 1'b1;
                  if (cmd_wr == CMD_WRITE) begin
                     we_d       = 1'b1;
                     address_d  = addr_q;
                     data_out_d = sh_n_c[DATA_W-1:0];
                  end
`ifdef SPI_REGIF_BURST_EN
                  addr_q_d = addr_q + ADDR_W'(1);
                  if (cmd_wr == CMD_READ) begin
                     address_d = addr_q + ADDR_W'(1);
                     re_d      = 1'b1;
                  end
`else
                  state_d = ST_HOLD;
`endif
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            state_d = ST_HOLD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ss rise aborts after any same-cycle sample; only a partial word errors.
      st_c = state_d;
      if (ss_rise && (state != ST_IDLE)) begin
         state_d = ST_IDLE;
         err_d   = (st_c == ST_CMD) || (st_c == ST_ADDR) ||
                   ((st_c == ST_DATA) && ((cnt_d != '0) || !(fin_c || wd_d)));
      end

      if ((state_d != ST_DATA) || (cmd_wr_d == CMD_WRITE)) miso_d = 1'b0;
      oe_d   = armed_d & ~ss_lvl;
      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_spi_regif_slave.sv
// Bench for spi_regif_slave: one mode-0 and one mode-3 instance, a bit-level
// SPI master, a registered read responder and a strobe scoreboard.
module tb_spi_regif_slave;

   localparam int H = 6;  // sclk half period in clk cycles

   localparam logic [1:0] K_WE  = 2'd0;
   localparam logic [1:0] K_RE  = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic        dut;
      logic [6:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk, rst;
   logic        sclk_a [2];
   logic        ss_a   [2];
   logic        mosi_a [2];
   logic        miso_a [2];
   logic        oe_a   [2];
   logic        we_a   [2];
   logic        re_a   [2];
   logic        busy_a [2];
   logic        ferr_a [2];
   logic [6:0]  addr_a [2];
   logic [31:0] dout_a [2];
   logic [31:0] din_a  [2];
   logic [31:0] rd_val [2];

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;

   spi_regif_slave #(.CPOL(1'b0), .CPHA(1'b0), .ADDR_W(7), .DATA_W(32)) u_m0 (
      .clk(clk), .rst(rst), .sclk(sclk_a[0]), .ss(ss_a[0]), .mosi(mosi_a[0]),
      .miso(miso_a[0]), .miso_oe(oe_a[0]), .address(addr_a[0]), .data_out(dout_a[0]),
      .we(we_a[0]), .re(re_a[0]), .data_in(din_a[0]), .busy(busy_a[0]), .frame_err(ferr_a[0])
   );

   spi_regif_slave #(.CPOL(1'b1), .CPHA(1'b1), .ADDR_W(7), .DATA_W(32)) u_m3 (
      .clk(clk), .rst(rst), .sclk(sclk_a[1]), .ss(ss_a[1]), .mosi(mosi_a[1]),
      .miso(miso_a[1]), .miso_oe(oe_a[1]), .address(addr_a[1]), .data_out(dout_a[1]),
      .we(we_a[1]), .re(re_a[1]), .data_in(din_a[1]), .busy(busy_a[1]), .frame_err(ferr_a[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: run did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input int d, input logic [6:0] a, input logic [31:0] dat);
      exp_t e;
      e.kind = k;
      e.dut  = (d == 1);
      e.addr = a;
      e.data = dat;
      exp_q.push_back(e);
   endtask

   // Compare one observed strobe against the scoreboard head.
   task automatic observe(input int d, input logic [1:0] k, input logic [6:0] a, input logic [31:0] dat);
      exp_t e;
      exp_t got;
      got.kind = k;
      got.dut  = (d == 1);
      got.addr = a;
      got.data = dat;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_strobe: got %0h required none", got);
      end else begin
         e = exp_q.pop_front();
         if (e !== got) begin
            n_fail++;
            $display("FAIL strobe: got %0h required %0h", got, e);
         end
      end
   endtask

   task automatic mon_loop();
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (we_a[d] === 1'b1) observe(d, K_WE, addr_a[d], dout_a[d]);
            if (re_a[d] === 1'b1) observe(d, K_RE, addr_a[d], 32'h0);
            if (ferr_a[d] === 1'b1) observe(d, K_ERR, 7'h0, 32'h0);
         end
      end
   endtask

   // Register bank: data valid during the clk following the re cycle.
   task automatic rsp_loop();
      logic p0, p1;
      forever begin
         @(negedge clk);
         p0 = re_a[0];
         p1 = re_a[1];
         @(posedge clk);
         #1;
         din_a[0] = p0 ? rd_val[0] : 32'hBAD0_BAD0;
         din_a[1] = p1 ? rd_val[1] : 32'hBAD1_BAD1;
      end
   endtask

   task automatic half();
      repeat (H) @(negedge clk);
   endtask

   task automatic xfer(input int d, input bit b, output bit r);
      bit p;
      p = (d == 1);  // instance 1 runs mode 3 (CPOL=CPHA=1)
      if (!p) begin
         mosi_a[d] = b;
         half();
         sclk_a[d] = 1'b1;
         r = miso_a[d];
         half();
         sclk_a[d] = 1'b0;
      end else begin
         sclk_a[d] = 1'b0;
         mosi_a[d] = b;
         half();
         sclk_a[d] = 1'b1;
         r = miso_a[d];
         half();
      end
   endtask

   task automatic ss_end(input int d);
      half();
      ss_a[d] = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // Full frame: cmd, 7 address bits, nd bits of the 96-bit MSB-first stream.
   task automatic frame(input int d, input bit wr, input logic [6:0] a, input logic [95:0] dat,
                        input int nd, output logic [31:0] rx, output bit z, output logic [1:0] st);
      bit r;
      rx = '0;
      z  = 1'b0;
      ss_a[d] = 1'b0;
      half();
      xfer(d, wr, r);
      z |= r;
      for (int i = 6; i >= 0; i--) begin
         xfer(d, a[i], r);
         z |= r;
      end
      st = {busy_a[d], oe_a[d]};
      for (int i = 0; i < nd; i++) begin
         xfer(d, dat[95-i], r);
         if (i < 32) rx = {rx[30:0], r};
      end
      ss_end(d);
   endtask

   task automatic check_zero(input int d, input string tag);
      chk($sformatf("%s_d%0d", tag, d),
          64'({miso_a[d], oe_a[d], addr_a[d], dout_a[d], we_a[d], re_a[d], busy_a[d], ferr_a[d]}),
          64'h0);
   endtask

   initial begin
      logic [31:0] rx;
      logic [1:0]  st;
      bit          z;
      bit          r;
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      sclk_a[0] = 1'b0;
      sclk_a[1] = 1'b1;
      ss_a[0]   = 1'b1;
      ss_a[1]   = 1'b1;
      mosi_a[0] = 1'b0;
      mosi_a[1] = 1'b0;
      din_a[0]  = 32'hBAD0_BAD0;
      din_a[1]  = 32'hBAD1_BAD1;
      rd_val[0] = 32'h0;
      rd_val[1] = 32'h0;
      fork
         mon_loop();
         rsp_loop();
      join_none

      repeat (4) @(negedge clk);
      check_zero(0, "in_reset");
      check_zero(1, "in_reset");
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check_zero(0, "after_reset");
      check_zero(1, "after_reset");

      // Mode 0 write 0x15 <- 0xDEADBEEF.
      push(K_WE, 0, 7'h15, 32'hDEAD_BEEF);
      frame(0, 1'b1, 7'h15, {32'hDEAD_BEEF, 64'h0}, 32, rx, z, st);
      chk("m0_wr_busy_oe", 64'(st), 64'h3);
      chk("m0_wr_miso_quiet", 64'(z), 64'h0);
      chk("m0_wr_data_out", 64'(dout_a[0]), 64'hDEAD_BEEF);
      chk("m0_wr_idle", 64'({busy_a[0], oe_a[0]}), 64'h0);

      // Mode 3 read 0x2A -> 0x12345678.
      rd_val[1] = 32'h1234_5678;
      push(K_RE, 1, 7'h2A, 32'h0);
      frame(1, 1'b0, 7'h2A, 96'h0, 32, rx, z, st);
      chk("m3_rd_busy_oe", 64'(st), 64'h3);
      chk("m3_rd_miso_quiet", 64'(z), 64'h0);
      chk("m3_rd_miso_word", 64'(rx), 64'h1234_5678);

      // Mode 0 read 0x01 -> 0xA5C30F81.
      rd_val[0] = 32'hA5C3_0F81;
      push(K_RE, 0, 7'h01, 32'h0);
      frame(0, 1'b0, 7'h01, 96'h0, 32, rx, z, st);
      chk("m0_rd_miso_quiet", 64'(z), 64'h0);
      chk("m0_rd_miso_word", 64'(rx), 64'hA5C3_0F81);

      // Mode 3 write at top address.
      push(K_WE, 1, 7'h7F, 32'h0000_0001);
      frame(1, 1'b1, 7'h7F, {32'h0000_0001, 64'h0}, 32, rx, z, st);
      chk("m3_wr_data_out", 64'(dout_a[1]), 64'h0000_0001);

      // Abort after 10 write data bits: one frame_err, no we.
      push(K_ERR, 0, 7'h0, 32'h0);
      frame(0, 1'b1, 7'h33, {32'hCAFE_F00D, 64'h0}, 10, rx, z, st);
      chk("abort_busy_low", 64'(busy_a[0]), 64'h0);
      chk("abort_data_out_kept", 64'(dout_a[0]), 64'hDEAD_BEEF);

      push(K_WE, 0, 7'h44, 32'h0123_4567);
      frame(0, 1'b1, 7'h44, {32'h0123_4567, 64'h0}, 32, rx, z, st);
      chk("after_abort_data_out", 64'(dout_a[0]), 64'h0123_4567);

      // Reset in the middle of the address phase.
      ss_a[0] = 1'b0;
      half();
      xfer(0, 1'b1, r);
      for (int i = 0; i < 3; i++) xfer(0, 1'b1, r);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero(0, "mid_rst");
      check_zero(1, "mid_rst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      half();
      ss_a[0] = 1'b1;
      repeat (12) @(negedge clk);
      push(K_WE, 0, 7'h55, 32'h89AB_CDEF);
      frame(0, 1'b1, 7'h55, {32'h89AB_CDEF, 64'h0}, 32, rx, z, st);
      chk("post_rst_data_out", 64'(dout_a[0]), 64'h89AB_CDEF);

`ifdef SPI_REGIF_BURST_EN
      // Burst write wraps 0x7F -> 0x00 -> 0x01.
      push(K_WE, 0, 7'h7F, 32'h1111_1111);
      push(K_WE, 0, 7'h00, 32'h2222_2222);
      push(K_WE, 0, 7'h01, 32'h3333_3333);
      frame(0, 1'b1, 7'h7F, {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 96, rx, z, st);
      chk("burst_last_addr", 64'(addr_a[0]), 64'h01);
`else
      // 40 extra clocks after a write are ignored; no frame_err.
      push(K_WE, 0, 7'h66, 32'h0F0F_0F0F);
      frame(0, 1'b1, 7'h66, {32'h0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF}, 72, rx, z, st);
      chk("hold_data_out", 64'(dout_a[0]), 64'h0F0F_0F0F);
      chk("hold_addr", 64'(addr_a[0]), 64'h66);
`endif

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
